// File: rtl/demux8_stream.sv
// demux8_stream: 1-to-8 valid/ready stream demultiplexer, one registered word per channel.
// Optional broadcast to all eight channels when DEMUX8_BCAST_EN is defined.
`default_nettype none

module demux8_stream #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           sel,
   input  logic                 bcast,
   input  logic [WIDTH-1:0]     in_data,
   output logic [7:0]           out_valid,
   input  logic [7:0]           out_ready,
   output logic [8*WIDTH-1:0]   out_data,
   output logic [3:0]           occupancy
);

   localparam int NCH = 8;

   logic [NCH-1:0]   valid_q;
   logic [NCH-1:0]   valid_d;
   logic [NCH-1:0]   drain;
   logic [NCH-1:0]   load;
   logic [3:0]       occ_q;
   logic [3:0]       occ_d;
   logic             xfer;
   logic [WIDTH-1:0] data_q [NCH];

   function automatic logic [3:0] popcnt8(input logic [NCH-1:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < NCH; i++) begin
         n = n + 4'(v[i]);
      end
      return n;
   endfunction

   // A channel can take a word if it is empty or is being drained this cycle.
   always_comb begin
      in_ready = !valid_q[sel] || out_ready[sel];
`ifdef DEMUX8_BCAST_EN
      if (bcast) begin
         in_ready = &(~valid_q | out_ready);
      end
`endif
   end

`ifndef DEMUX8_BCAST_EN
   logic unused_bcast;
   assign unused_bcast = bcast;
`endif

   assign xfer  = in_valid && in_ready;
   assign drain = valid_q & out_ready;

   always_comb begin
      load = '0;
      if (xfer) begin
         load[sel] = 1'b1;
`ifdef DEMUX8_BCAST_EN
         if (bcast) begin
            load = '1;
         end
`endif
      end
   end

   // A load on a draining channel wins, so the valid bit stays set.
   assign valid_d = (valid_q & ~drain) | load;
   assign occ_d   = popcnt8(valid_d);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         occ_q   <= 4'd0;
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
      end
   end

   generate
      for (genvar k = 0; k < NCH; k++) begin : g_ch
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               data_q[k] <= '0;
            end else if (load[k]) begin
               data_q[k] <= in_data;
            end
         end
         assign out_data[k*WIDTH +: WIDTH] = data_q[k];
      end
   endgenerate

   assign out_valid = valid_q;
   assign occupancy = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_demux8_stream.sv
// tb_demux8_stream: directed stimulus, per-channel holding-slot model, negedge compare.
`default_nettype none

module tb_demux8_stream;

   localparam int W = 16;
`ifdef DEMUX8_BCAST_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [2:0]     sel;
   logic           bcast;
   logic [W-1:0]   in_data;
   logic [7:0]     out_valid;
   logic [7:0]     out_ready;
   logic [8*W-1:0] out_data;
   logic [3:0]     occupancy;

   int n_cmp = 0;
   int n_bad = 0;

   demux8_stream #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .bcast(bcast), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // Model: each channel is a slot that is either empty or holds one word.
   bit         m_full [8];
   logic [W-1:0] m_word [8];
   int         m_occ;

   function automatic bit model_ready();
      bit r;
      if (BC && bcast) begin
         r = 1'b1;
         for (int k = 0; k < 8; k++) if (m_full[k] && !out_ready[k]) r = 1'b0;
      end else begin
         r = !m_full[sel] || out_ready[sel];
      end
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin : model_upd
      bit acc;
      if (reset) begin
         for (int k = 0; k < 8; k++) begin
            m_full[k] = 1'b0;
            m_word[k] = '0;
         end
         m_occ = 0;
      end else begin
         acc = in_valid && model_ready();
         for (int k = 0; k < 8; k++) begin
            if (m_full[k] && out_ready[k]) begin
               m_full[k] = 1'b0;
               m_occ     = m_occ - 1;
            end
            if (acc && ((BC && bcast) || sel == 3'(k))) begin
               m_full[k] = 1'b1;
               m_word[k] = in_data;
               m_occ     = m_occ + 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : compare
      logic [7:0]   ev;
      logic [127:0] ed;
      for (int k = 0; k < 8; k++) begin
         ev[k]          = m_full[k];
         ed[k*W +: W]   = m_word[k];
      end
      chk("out_valid", 128'(out_valid), 128'(ev));
      chk("out_data",  128'(out_data),  ed);
      chk("occupancy", 128'(occupancy), 128'(m_occ));
      chk("in_ready",  128'(in_ready),  128'(model_ready()));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic put(input logic [2:0] s, input logic [W-1:0] d);
      in_valid = 1'b1;
      sel      = s;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; sel = 3'd0; bcast = 1'b0;
      in_data = '0; out_ready = 8'h00;
      tick(); tick(); settle();
      chk("lit_rst_valid", 128'(out_valid), 128'h0);
      chk("lit_rst_occ",   128'(occupancy), 128'h0);
      chk("lit_rst_ready", 128'(in_ready),  128'h1);
      reset = 1'b0;
      tick();

      // Single routing, then a blocked second word to the same channel.
      put(3'd5, 16'hBEEF); settle();
      chk("lit_route_valid", 128'(out_valid), 128'h20);
      chk("lit_route_data",  128'(out_data[5*W +: W]), 128'hBEEF);
      chk("lit_route_occ",   128'(occupancy), 128'h1);
      in_valid = 1'b1; sel = 3'd5; in_data = 16'h1234; settle();
      chk("lit_block_ready", 128'(in_ready), 128'h0);
      tick(); tick();
      out_ready = 8'h20; settle();
      chk("lit_unblock_ready", 128'(in_ready), 128'h1);
      tick();
      in_valid = 1'b0; out_ready = 8'h00; settle();
      chk("lit_replace_data", 128'(out_data[5*W +: W]), 128'h1234);
      chk("lit_replace_occ",  128'(occupancy), 128'h1);
      out_ready = 8'h20; tick(); out_ready = 8'h00;

      // Back-to-back on channel 2 with its consumer always ready.
      out_ready = 8'h04; in_valid = 1'b1; sel = 3'd2;
      for (int i = 1; i <= 3; i++) begin
         in_data = W'(i); settle();
         chk("lit_b2b_ready", 128'(in_ready), 128'h1);
         tick();
      end
      in_valid = 1'b0; settle();
      chk("lit_b2b_data",  128'(out_data[2*W +: W]), 128'h3);
      chk("lit_b2b_valid", 128'(out_valid), 128'h04);
      tick(); out_ready = 8'h00;

      // Fill all eight channels, then drain everything in one cycle.
      for (int k = 0; k < 8; k++) put(3'(k), 16'h1000 + W'(k));
      settle();
      chk("lit_fill_valid", 128'(out_valid), 128'hFF);
      chk("lit_fill_occ",   128'(occupancy), 128'h8);
      chk("lit_fill_data7", 128'(out_data[7*W +: W]), 128'h1007);
      out_ready = 8'hFF; tick(); out_ready = 8'h00; settle();
      chk("lit_drain_occ", 128'(occupancy), 128'h0);

      // Drain channel 3 while loading channel 6.
      put(3'd3, 16'h3333);
      out_ready = 8'h08; in_valid = 1'b1; sel = 3'd6; in_data = 16'h6666; settle();
      chk("lit_dl_ready", 128'(in_ready), 128'h1);
      tick();
      in_valid = 1'b0; out_ready = 8'h00; settle();
      chk("lit_dl_valid", 128'(out_valid), 128'h40);
      chk("lit_dl_occ",   128'(occupancy), 128'h1);
      out_ready = 8'h40; tick(); out_ready = 8'h00;

      // Broadcast request while channel 4 is stalled.
      put(3'd4, 16'h4444);
      in_valid = 1'b1; bcast = 1'b1; sel = 3'd1; in_data = 16'hA5A5; settle();
`ifdef DEMUX8_BCAST_EN
      chk("lit_bc_block", 128'(in_ready), 128'h0);
      tick();
      out_ready = 8'h10; settle();
      chk("lit_bc_ready", 128'(in_ready), 128'h1);
      tick();
      in_valid = 1'b0; bcast = 1'b0; out_ready = 8'h00; settle();
      chk("lit_bc_valid", 128'(out_valid), 128'hFF);
      chk("lit_bc_occ",   128'(occupancy), 128'h8);
      chk("lit_bc_data0", 128'(out_data[0 +: W]), 128'hA5A5);
`else
      chk("lit_nobc_ready", 128'(in_ready), 128'h1);
      tick();
      in_valid = 1'b0; bcast = 1'b0; settle();
      chk("lit_nobc_valid", 128'(out_valid), 128'h12);
      chk("lit_nobc_occ",   128'(occupancy), 128'h2);
      chk("lit_nobc_data4", 128'(out_data[4*W +: W]), 128'h4444);
`endif
      out_ready = 8'hFF; tick(); out_ready = 8'h00;

      // Reset asserted asynchronously right after a word is accepted.
      put(3'd7, 16'h7777);
      #2 reset = 1'b1;
      #1;
      chk("lit_mid_valid", 128'(out_valid), 128'h0);
      chk("lit_mid_occ",   128'(occupancy), 128'h0);
      chk("lit_mid_ready", 128'(in_ready),  128'h1);
      tick(); reset = 1'b0; tick();
      put(3'd0, 16'hCAFE); settle();
      chk("lit_post_valid", 128'(out_valid), 128'h01);
      chk("lit_post_data",  128'(out_data[0 +: W]), 128'hCAFE);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
